// File: rtl/formula_2_pkg.sv
// Shared constants for the formula_2 datapath and its credit collector.
//   FORMULA_2_WIDTH   : result width of formula_2_pipe
//   SQRT_PIPE_STAGES  : stages in one square-root unit
//   FORMULA_2_LATENCY : arg_vld to res_vld latency of formula_2_pipe
//   FORMULA_2_DEPTH   : default result buffer depth and initial credit count
//   CREDIT_W          : credit counter width for the default depth
package formula_2_pkg;

  localparam int FORMULA_2_WIDTH   = 32;
  localparam int SQRT_PIPE_STAGES  = 16;
  localparam int FORMULA_2_LATENCY = 3 * SQRT_PIPE_STAGES + 2;
  localparam int FORMULA_2_DEPTH   = 64;
  localparam int CREDIT_W          = $clog2(FORMULA_2_DEPTH + 1);

  // Credit counter width for an arbitrary buffer depth (counts 0..depth).
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/formula_2_credit_collector_if.sv
// Bus between the credit collector and its surroundings.
//   master : upstream/pipe/downstream side (drives up_vld, res_vld, res, down_rdy)
//   slave  : the collector (drives up_rdy, issue_vld, down_vld, down_data,
//            credits, overflow)
interface formula_2_credit_collector_if
  import formula_2_pkg::*;
#(
  parameter int WIDTH = FORMULA_2_WIDTH,
  parameter int DEPTH = FORMULA_2_DEPTH
);

  localparam int CW = credit_width(DEPTH);

  logic             up_vld;
  logic             up_rdy;
  logic             issue_vld;
  logic             res_vld;
  logic [WIDTH-1:0] res;
  logic             down_vld;
  logic [WIDTH-1:0] down_data;
  logic             down_rdy;
  logic [CW-1:0]    credits;
  logic             overflow;

  modport master (
    output up_vld, res_vld, res, down_rdy,
    input  up_rdy, issue_vld, down_vld, down_data, credits, overflow
  );

  modport slave (
    input  up_vld, res_vld, res, down_rdy,
    output up_rdy, issue_vld, down_vld, down_data, credits, overflow
  );

endinterface

// File: rtl/formula_2_credit_cnt.sv
// Up/down credit counter that resets to depth and never leaves 0..depth.
//   clk, rst  : clock, asynchronous active-low reset
//   i_inc     : return one credit (result popped downstream)
//   i_dec     : consume one credit (argument issued into the pipe)
//   o_cnt     : current credit count
//   o_nonzero : at least one credit available
module formula_2_credit_cnt #(
  parameter int depth = 64,
  parameter int CW    = $clog2(depth + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic          o_nonzero
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(depth);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  // Credit count: simultaneous inc and dec cancel; the ends of the range hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= CNT_MAX;
    end else begin
      case ({i_inc, i_dec})
        2'b10: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
          else                  r_cnt <= r_cnt;
        end
        2'b01: begin
          if (r_cnt != CNT_ZERO) r_cnt <= r_cnt - CNT_ONE;
          else                   r_cnt <= r_cnt;
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_cnt     = r_cnt;
  assign o_nonzero = (r_cnt != CNT_ZERO);

endmodule

// File: rtl/formula_2_credit_collector.sv
// Credit-based collector around formula_2_pipe. Arguments are issued only
// while a credit (a guaranteed free result slot) exists; pipe results are
// stored in an in-order circular buffer and offered on a valid/ready output.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave modport of formula_2_credit_collector_if
//              (up_vld/up_rdy/issue_vld, res_vld/res,
//               down_vld/down_data/down_rdy, credits, overflow)
module formula_2_credit_collector
  import formula_2_pkg::*;
#(
  parameter int width = FORMULA_2_WIDTH,
  parameter int depth = FORMULA_2_DEPTH
) (
  input logic                         clk,
  input logic                         rst,
  formula_2_credit_collector_if.slave bus
);

  localparam int CW = credit_width(depth);
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(depth);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(depth - 1);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Explicit wrap compare so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    logic [AW-1:0] n;
    if (p == PTR_LAST) n = PTR_ZERO;
    else               n = p + PTR_ONE;
    return n;
  endfunction

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic          w_credit_nz;
  logic [CW-1:0] w_credits;
  logic          w_issue;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_reject;

  assign w_issue  = bus.up_vld & w_credit_nz;
  assign w_pop    = (r_count != CNT_ZERO) & bus.down_rdy;
  assign w_full   = (r_count == CNT_FULL);
  // A full buffer still takes a result when the head leaves in the same cycle.
  assign w_push   = bus.res_vld & (~w_full | w_pop);
  assign w_reject = bus.res_vld & w_full & ~w_pop;

  formula_2_credit_cnt #(
    .depth (depth),
    .CW    (CW)
  ) u_credit_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (w_pop),
    .i_dec     (w_issue),
    .o_cnt     (w_credits),
    .o_nonzero (w_credit_nz)
  );

  // Result storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.res;
  end

  // Buffer pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= PTR_ZERO;
      r_rd_ptr   <= PTR_ZERO;
      r_count    <= CNT_ZERO;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_reject) r_overflow <= 1'b1;
    end
  end

  assign bus.up_rdy    = w_credit_nz;
  assign bus.issue_vld = w_issue;
  assign bus.down_vld  = (r_count != CNT_ZERO);
  assign bus.down_data = r_mem[r_rd_ptr];
  assign bus.credits   = w_credits;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_formula_2_credit_collector.sv
`timescale 1ns/1ps
module tb_formula_2_credit_collector;
  import formula_2_pkg::*;

  localparam int D0  = 64;
  localparam int D1  = 5;
  localparam int LAT = FORMULA_2_LATENCY;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  formula_2_credit_collector_if #(.WIDTH(32), .DEPTH(D0)) bus0 ();
  formula_2_credit_collector_if #(.WIDTH(32), .DEPTH(D1)) bus1 ();

  formula_2_credit_collector #(.width(32), .depth(D0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave));
  formula_2_credit_collector #(.width(32), .depth(D1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stand-in for formula_2_pipe on instance 0: fixed latency, result = tag
  logic [31:0] arg_tag = 32'd0;
  logic        p_vld [LAT];
  logic [31:0] p_dat [LAT];
  logic        f_vld = 1'b0;
  logic [31:0] f_dat = 32'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin p_vld[i] <= 1'b0; p_dat[i] <= 32'd0; end
    end else begin
      p_vld[0] <= bus0.issue_vld;
      p_dat[0] <= arg_tag;
      for (int i = 1; i < LAT; i++) begin p_vld[i] <= p_vld[i-1]; p_dat[i] <= p_dat[i-1]; end
    end
  end

  assign bus0.res_vld = p_vld[LAT-1] | f_vld;
  assign bus0.res     = f_vld ? f_dat : p_dat[LAT-1];

  // Behavioural model: queue of stored results, credit count, sticky error
  int          mcred [2];
  bit          movf  [2];
  logic [31:0] mq    [2][$];

  function automatic int mdep(input int k);
    return (k == 0) ? D0 : D1;
  endfunction

  task automatic mstep(input int k, input logic uv, input logic dr, input logic rv, input logic [31:0] rd);
    int cr, sz;
    bit iss, pop, acc;
    cr  = mcred[k];
    sz  = mq[k].size();
    iss = uv && (cr != 0);
    pop = (sz != 0) && dr;
    acc = rv && ((sz < mdep(k)) || pop);
    if (pop) void'(mq[k].pop_front());
    if (acc) mq[k].push_back(rd);
    if (rv && !acc) movf[k] <= 1'b1;
    cr = cr + (pop ? 1 : 0) - (iss ? 1 : 0);
    if (cr > mdep(k)) cr = mdep(k);
    if (cr < 0) cr = 0;
    mcred[k] <= cr;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        mcred[k] <= mdep(k);
        movf[k]  <= 1'b0;
        mq[k].delete();
      end
    end else begin
      mstep(0, bus0.up_vld, bus0.down_rdy, bus0.res_vld, bus0.res);
      mstep(1, bus1.up_vld, bus1.down_rdy, bus1.res_vld, bus1.res);
    end
  end

  task automatic cmp_inst(input int k, input logic uv, input logic ur, input logic iv,
                          input logic dv, input logic [31:0] dd, input int cr, input logic ov);
    bit ur_e, dv_e;
    ur_e = (mcred[k] != 0);
    dv_e = (mq[k].size() != 0);
    chk($sformatf("m%0d_up_rdy", k), {63'd0, ur}, {63'd0, ur_e});
    chk($sformatf("m%0d_issue_vld", k), {63'd0, iv}, {63'd0, (uv && ur_e)});
    chk($sformatf("m%0d_down_vld", k), {63'd0, dv}, {63'd0, dv_e});
    chk($sformatf("m%0d_credits", k), 64'(cr), 64'(mcred[k]));
    chk($sformatf("m%0d_overflow", k), {63'd0, ov}, {63'd0, movf[k]});
    if (dv_e) chk($sformatf("m%0d_down_data", k), {32'd0, dd}, {32'd0, mq[k][0]});
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      cmp_inst(0, bus0.up_vld, bus0.up_rdy, bus0.issue_vld, bus0.down_vld,
               bus0.down_data, int'(bus0.credits), bus0.overflow);
      cmp_inst(1, bus1.up_vld, bus1.up_rdy, bus1.issue_vld, bus1.down_vld,
               bus1.down_data, int'(bus1.credits), bus1.overflow);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int          lat, nis, npop;
  bit          found;
  logic [31:0] last;
  logic [31:0] popped [$];

  initial begin
    bus0.up_vld = 1'b0; bus0.down_rdy = 1'b0;
    bus1.up_vld = 1'b0; bus1.down_rdy = 1'b0; bus1.res_vld = 1'b0; bus1.res = 32'd0;
    wait_cycles(3);
    chk("rst_credits", 64'(bus0.credits), 64'd64);
    chk("rst_up_rdy", {63'd0, bus0.up_rdy}, 64'd1);
    chk("rst_down_vld", {63'd0, bus0.down_vld}, 64'd0);
    chk("rst_issue_vld", {63'd0, bus0.issue_vld}, 64'd0);
    chk("rst_overflow", {63'd0, bus0.overflow}, 64'd0);
    @(negedge clk); rst = 1'b1;
    tick();

    // Single transaction: a=6, b=5, c=16 yields 3
    arg_tag = 32'd3; bus0.up_vld = 1'b1; bus0.down_rdy = 1'b1;
    tick();
    bus0.up_vld = 1'b0;
    lat = 0; found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (bus0.down_vld) found = 1'b1;
      else begin tick(); lat++; end
    end
    chk("t1_found", {63'd0, found}, 64'd1);
    chk("t1_latency", 64'(lat), 64'(LAT));
    chk("t1_data", {32'd0, bus0.down_data}, 64'd3);
    tick();
    chk("t1_down_vld_drop", {63'd0, bus0.down_vld}, 64'd0);
    chk("t1_credits", 64'(bus0.credits), 64'd64);
    chk("t1_overflow", {63'd0, bus0.overflow}, 64'd0);

    // 70 back-to-back requests with a stalled consumer
    bus0.down_rdy = 1'b0; nis = 0;
    for (int i = 0; i < 70; i++) begin
      arg_tag = 32'hA000 + 32'(i); bus0.up_vld = 1'b1;
      #1;
      if (bus0.issue_vld) nis++;
      tick();
    end
    bus0.up_vld = 1'b0;
    chk("t2_issues", 64'(nis), 64'd64);
    chk("t2_up_rdy", {63'd0, bus0.up_rdy}, 64'd0);
    chk("t2_credits", 64'(bus0.credits), 64'd0);
    wait_cycles(60);
    chk("t2_overflow", {63'd0, bus0.overflow}, 64'd0);
    chk("t2_head", {32'd0, bus0.down_data}, 64'h0000_A000);

    // Full buffer: stray result together with a pop is accepted
    bus0.down_rdy = 1'b1; f_vld = 1'b1; f_dat = 32'hDEAD;
    tick();
    f_vld = 1'b0; bus0.down_rdy = 1'b0;
    chk("t3_overflow", {63'd0, bus0.overflow}, 64'd0);
    chk("t3_up_rdy", {63'd0, bus0.up_rdy}, 64'd1);
    chk("t3_credits", 64'(bus0.credits), 64'd1);
    chk("t3_head", {32'd0, bus0.down_data}, 64'h0000_A001);

    // credits=1: issue and pop together leave the count at 1
    arg_tag = 32'hB000; bus0.up_vld = 1'b1; bus0.down_rdy = 1'b1;
    tick();
    bus0.up_vld = 1'b0; bus0.down_rdy = 1'b0;
    chk("t4_credits", 64'(bus0.credits), 64'd1);
    chk("t4_up_rdy", {63'd0, bus0.up_rdy}, 64'd1);
    chk("t4_head", {32'd0, bus0.down_data}, 64'h0000_A002);
    wait_cycles(55);

    // Full buffer, stray result without a pop: dropped, sticky error
    f_vld = 1'b1; f_dat = 32'hDEAD;
    tick();
    f_vld = 1'b0;
    chk("t5_overflow", {63'd0, bus0.overflow}, 64'd1);
    chk("t5_head", {32'd0, bus0.down_data}, 64'h0000_A002);
    wait_cycles(3);
    chk("t5_sticky", {63'd0, bus0.overflow}, 64'd1);

    // Drain in order
    bus0.down_rdy = 1'b1; npop = 0; last = 32'd0;
    for (int c = 0; c < 80 && bus0.down_vld; c++) begin
      last = bus0.down_data; npop++;
      tick();
    end
    bus0.down_rdy = 1'b0;
    chk("t6_pops", 64'(npop), 64'd64);
    chk("t6_last", {32'd0, last}, 64'h0000_B000);
    chk("t6_credits", 64'(bus0.credits), 64'd64);
    chk("t6_empty", {63'd0, bus0.down_vld}, 64'd0);

    // Reset in the middle of a stream with 10 results buffered
    for (int i = 0; i < 10; i++) begin
      arg_tag = 32'hC000 + 32'(i); bus0.up_vld = 1'b1;
      tick();
    end
    bus0.up_vld = 1'b0;
    wait_cycles(55);
    chk("t7_buffered", {63'd0, bus0.down_vld}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("t7_rst_down_vld", {63'd0, bus0.down_vld}, 64'd0);
    chk("t7_rst_credits", 64'(bus0.credits), 64'd64);
    chk("t7_rst_overflow", {63'd0, bus0.overflow}, 64'd0);
    wait_cycles(2);
    @(negedge clk); rst = 1'b1;
    tick();
    arg_tag = 32'hD000; bus0.up_vld = 1'b1; bus0.down_rdy = 1'b1;
    tick();
    bus0.up_vld = 1'b0;
    chk("t7_resume_credits", 64'(bus0.credits), 64'd63);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (bus0.down_vld) found = 1'b1;
      else tick();
    end
    chk("t7_resume_found", {63'd0, found}, 64'd1);
    chk("t7_resume_data", {32'd0, bus0.down_data}, 64'h0000_D000);
    tick();
    bus0.down_rdy = 1'b0;

    // depth=5 instance: 12 results through a wrapping buffer
    popped.delete();
    for (int i = 0; i < 12; i++) begin
      bus1.up_vld = 1'b1; bus1.res_vld = 1'b1; bus1.res = 32'h500 + 32'(i);
      bus1.down_rdy = (i >= 3);
      #1;
      if (bus1.down_vld && bus1.down_rdy) popped.push_back(bus1.down_data);
      tick();
    end
    bus1.up_vld = 1'b0; bus1.res_vld = 1'b0; bus1.down_rdy = 1'b1;
    for (int c = 0; c < 10 && bus1.down_vld; c++) begin
      popped.push_back(bus1.down_data);
      tick();
    end
    bus1.down_rdy = 1'b0;
    chk("t8_pops", 64'(popped.size()), 64'd12);
    for (int j = 0; j < popped.size(); j++)
      chk($sformatf("t8_order_%0d", j), {32'd0, popped[j]}, 64'(32'h500 + 32'(j)));
    chk("t8_credits", 64'(bus1.credits), 64'd5);
    chk("t8_overflow", {63'd0, bus1.overflow}, 64'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/formula_2_credit_collector.md
Name: formula_2_credit_collector

Overview:
- Sits between the upstream argument source, the formula_2_pipe datapath and a downstream consumer that can stall.
- formula_2_pipe has no backpressure. This block issues arguments into it only when a result slot is guaranteed free.
- It buffers pipe results in an in-order circular store and presents them on a valid/ready output.
- The credit scheme makes result loss impossible when the upstream honours up_rdy.

Parameters:
- width, 32: result data width; matches the pipe res width.
- depth, 64: result buffer entries and initial credit count; must be ≥ 2; must be ≥ the pipe latency (50) to sustain one issue per cycle.

Ports:
- clk  in  1  clock; all logic is posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- up_vld  in  1  upstream has an argument triple ready.
- up_rdy  out  1  a credit is available; the upstream may transfer.
- issue_vld  out  1  drives the pipe arg_vld; equals up_vld & up_rdy, combinational.
- res_vld  in  1  pipe result valid.
- res  in  width  pipe result data.
- down_vld  out  1  buffer non-empty.
- down_data  out  width  head-of-buffer data.
- down_rdy  in  1  downstream accepts.
- credits  out  $clog2(depth+1)  current credit count.
- overflow  out  1  sticky error; a result arrived with no free entry.

Behaviour:
- Reset (rst=0, async): credits=depth; wr_ptr=rd_ptr=0; count=0; overflow=0; down_vld=0; up_rdy=1; issue_vld=0 when up_vld=0. Buffer contents are don't-care.
- Issue: issue = up_vld & up_rdy; up_rdy = (credits != 0).
- Pop: pop = down_vld & down_rdy.
- Credit update, per cycle:
  - issue only: credits-1.
  - pop only: credits+1.
  - both or neither: unchanged.
- Invariant: credits + count + in-flight = depth. The counter can never go below 0 or above depth.
- Push: res_vld writes res to mem[wr_ptr]. The push is accepted when count < depth, or when count == depth and a pop occurs in the same cycle.
- Rejected push: the data is dropped, overflow is set and stays set until reset, and pointers and count are unchanged.
- Count update:
  - accepted push only: +1.
  - pop only: −1.
  - both: unchanged.
- Pointers: advance by 1 on accepted push (wr_ptr) and on pop (rd_ptr). Each wraps from depth-1 to 0 by explicit compare, so non-power-of-2 depth is supported.
- Output side:
  - down_vld = (count != 0).
  - down_data = mem[rd_ptr]; registered storage, combinational index.
  - No push-to-output bypass: a result written into an empty buffer shows down_vld=1 on the next cycle.
- Ordering: results leave in arrival order, which is issue order because the pipe is in-order.
- Latencies:
  - res_vld to down_vld: 1 cycle.
  - pop to up_rdy rising (from credits=0): 1 cycle.
- Reset mid-operation: every state element clears immediately; the pipe shares this reset, so no stale results follow.
- No other error outputs; res_vld while count < depth is always legal.

Decomposition:
- Package formula_2_pkg:
  - FORMULA_2_WIDTH=32.
  - SQRT_PIPE_STAGES=16.
  - FORMULA_2_LATENCY=3*SQRT_PIPE_STAGES+2 (=50).
  - Default depth constant 64.
  - CREDIT_W=$clog2(depth+1).
- One natural sub-module, formula_2_credit_cnt: an up/down saturating-safe counter with reset value depth, inc/dec inputs, and a nonzero flag output.
- The storage array and pointers stay inline.
- Top-level test wrapper: instantiates this block with formula_2_pipe, connecting issue_vld to arg_vld and res/res_vld back.

Test Plan:
- Single transaction, a=6, b=5, c=16, down_rdy=1 → one down_vld pulse with down_data=3 (sqrt(16)=4, sqrt(9)=3, sqrt(9)=3) about 51 cycles after issue; credits returns to 64; overflow=0.
- 70 back-to-back up_vld with down_rdy=0, depth=64 → exactly 64 issues; then up_rdy=0 and credits=0. All 64 results stored with no overflow. Raising down_rdy drains them in issue order, and up_rdy=1 one cycle after the first pop.
- With credits=1, issue and pop in the same cycle → credits stays 1 and up_rdy stays 1; count decrements only if no push that cycle.
- Buffer full (count=64) with a forced stray res_vld=1, res=32'hDEAD and down_rdy=0 → overflow=1 and sticky; count=64; head data unchanged. The same event with down_rdy=1 → push accepted, overflow stays 0.
- depth=5 override, 12 results pushed and popped interleaved → pointers wrap 4→0; data order is preserved.
- Assert rst=0 mid-stream with 10 entries buffered → down_vld=0, credits=64 and overflow=0 asynchronously, before the next clk edge; after release, normal issue resumes.
